// File: rtl/sfifo_wr_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and grant-id width.
package sfifo_wr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // A single requester would still need a 1-bit id port.
    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_rr_select.sv
// Combinational round-robin pick: first set bit of req searching upward from last_id+1 with wrap.
module rr_select #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic             any,
    output logic [ID_W-1:0]  pick_id
);

    int idx;

    // Walk the search order backwards so the closest candidate to last_id+1 is written last.
    always_comb begin
        any     = 1'b0;
        pick_id = '0;
        idx     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_id) + k) % N_REQ;
            if (req[ID_W'(idx)]) begin
                any     = 1'b1;
                pick_id = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Packet-locked round-robin arbiter in front of a synchronous FIFO write port; grant one cycle after request, 1 beat/cycle while not full.
// Optional burst cap (define SFIFO_WR_ARB_BURST_CAP_EN) forces re-arbitration after MAX_BURST accepted beats.
module sfifo_wr_arbiter
    import sfifo_wr_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BURST = 16,
    localparam int ID_W      = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       fifo_data,
    output logic                    fifo_wen,
    input  logic                    fifo_full,
    output logic                    grant_valid,
    output logic [ID_W-1:0]         grant_id
);

    if (N_REQ < 2 || MAX_BURST < 2) begin : g_bad_param
        $error("sfifo_wr_arbiter: N_REQ and MAX_BURST must both be at least 2");
    end

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic              rr_any;
    logic [ID_W-1:0]   rr_pick;
    logic              locked;
    logic              accept;
    logic              cap_hit;
    logic              release_grant;
    logic [DATA_W-1:0] beats [N_REQ];

    rr_select #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_select (
        .req     (req_valid),
        .last_id (last_id_q),
        .any     (rr_any),
        .pick_id (rr_pick)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            beats[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign locked        = (state_q == ST_LOCK);
    assign accept        = locked & req_valid[grant_id_q] & ~fifo_full;
    assign release_grant = accept & (req_last[grant_id_q] | cap_hit);

    always_comb begin
        req_ready = '0;
        if (locked) begin
            req_ready[grant_id_q] = ~fifo_full;
        end
    end

    assign fifo_wen    = accept;
    assign fifo_data   = beats[grant_id_q];
    assign grant_valid = locked;
    assign grant_id    = grant_id_q;

`ifdef SFIFO_WR_ARB_BURST_CAP_EN
    localparam int CNT_W = $clog2(MAX_BURST);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cap_hit = (cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (release_grant) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign cap_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    state_d    = ST_LOCK;
                    grant_id_d = rr_pick;
                end
            end
            ST_LOCK: begin
                if (release_grant) begin
                    state_d   = ST_IDLE;
                    last_id_d = grant_id_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(N_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
        end
    end

endmodule
